num_display_writer: RTL

//  Parametrised successor to the single-digit column writer for the LED matrix.

---
 rtl/led_matrix_pkg.sv | 35 +++
 rtl/digit_font_rom.sv | 57 +++++
 rtl/num_display_writer.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/led_matrix_pkg.sv
// Shared types and helpers for the LED matrix number writer.
// Contents: redraw state encoding, BCD digit type, font geometry and a
// single-digit BCD step used to build the multi-digit carry/borrow chain.
package led_matrix_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      FLUSH = 2'd2
   } writer_state_t;

   typedef logic [3:0] bcd_digit_t;

   localparam int FONT_COLS = 5;
   localparam int FONT_ROWS = 8;

   // One BCD digit of an increment/decrement chain.
   // Returns {carry_or_borrow_out, new_digit}. With cin low the digit passes through.
   function automatic logic [4:0] bcd_digit_step(input bcd_digit_t dig,
                                                 input logic       up,
                                                 input logic       cin);
      logic [4:0] res;
      if (!cin) begin
         res = {1'b0, dig};
      end else if (up) begin
         if (dig == 4'd9) res = {1'b1, 4'd0};
         else             res = {1'b0, dig + 4'd1};
      end else begin
         if (dig == 4'd0) res = {1'b1, 4'd9};
         else             res = {1'b0, dig - 4'd1};
      end
      return res;
   endfunction

endpackage

// File: rtl/digit_font_rom.sv
// Synchronous digit font ROM: one glyph column per read, one-cycle latency.
// Codes 10..15 and columns beyond the glyph width read as blank.
module digit_font_rom
   import led_matrix_pkg::*;
#(
   parameter int ROWS  = 8,
   parameter int COL_W = 3
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             rd_en,
   input  bcd_digit_t       digit,
   input  logic [COL_W-1:0] col,
   output logic [ROWS-1:0]  data
);

   logic [FONT_COLS*FONT_ROWS-1:0] glyph_s;
   logic [FONT_ROWS-1:0]           column_s;

   // Glyph lookup: five columns packed leftmost column in the top byte, bit0 = top row.
   always_comb begin
      case (digit)
         4'd0:    glyph_s = 40'h3E_51_49_45_3E;
         4'd1:    glyph_s = 40'h00_42_7F_40_00;
         4'd2:    glyph_s = 40'h42_61_51_49_46;
         4'd3:    glyph_s = 40'h21_41_45_4B_31;
         4'd4:    glyph_s = 40'h18_14_12_7F_10;
         4'd5:    glyph_s = 40'h27_45_45_45_39;
         4'd6:    glyph_s = 40'h3C_4A_49_49_30;
         4'd7:    glyph_s = 40'h01_71_09_05_03;
         4'd8:    glyph_s = 40'h36_49_49_49_36;
         4'd9:    glyph_s = 40'h06_49_49_29_1E;
         default: glyph_s = 40'h00_00_00_00_00;
      endcase
   end

   // Column select; anything past the font width is blank.
   always_comb begin
      if (int'(col) < FONT_COLS) begin
         column_s = glyph_s[FONT_ROWS*(FONT_COLS-1-int'(col)) +: FONT_ROWS];
      end else begin
         column_s = '0;
      end
   end

   // Registered read port; output holds between reads so the write data stays stable.
   always_ff @(posedge clk) begin
      if (rst) begin
         data <= '0;
      end else if (rd_en) begin
         data <= ROWS'(column_s);
      end else begin
         data <= data;
      end
   end

endmodule

// File: rtl/num_display_writer.sv
// num_display_writer: NDIGITS-digit decimal up/down counter driven by button
// pulses; after every change (and after reset) all digit columns are redrawn
// into the framebuffer, most-significant digit leftmost.
// Optional build macro: LEADING_ZERO_BLANK_EN -- leading zero digits are
// written as blank columns (digit0 always drawn); write count/timing unchanged.
module num_display_writer
   import led_matrix_pkg::*;
#(
   parameter int NDIGITS    = 2,
   parameter int GLYPH_COLS = 5,
   parameter int GAP_COLS   = 1,
   parameter int ROWS       = 8,
   parameter int FB_ADDR_W  = 6,
   parameter int BASE_COL   = 0
)(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   inc_pulse,
   input  logic                   dec_pulse,
   output logic [FB_ADDR_W-1:0]   fb_addr,
   output logic [ROWS-1:0]        fb_wdata,
   output logic                   fb_we,
   output logic                   busy,
   output logic                   done,
   output logic [4*NDIGITS-1:0]   value_bcd
);

   localparam int COLS_PER = GLYPH_COLS + GAP_COLS;
   localparam int TOTAL    = NDIGITS * COLS_PER;
   localparam int COL_W    = (TOTAL > 1) ? $clog2(TOTAL) : 1;
   localparam int G_W      = (COLS_PER > 1) ? $clog2(COLS_PER) : 1;

   if (BASE_COL + TOTAL > 2**FB_ADDR_W) begin : g_addr_range_check
      $error("num_display_writer: BASE_COL + TOTAL exceeds framebuffer address range");
   end
   if (NDIGITS < 1 || NDIGITS > 4) begin : g_ndigits_check
      $error("num_display_writer: NDIGITS must be 1..4");
   end

   writer_state_t          state_r;
   logic [4*NDIGITS-1:0]   value_r;
   logic [4*NDIGITS-1:0]   value_next_s;
   logic [COL_W-1:0]       col_r;
   logic [G_W-1:0]         glyph_r;
   logic [1:0]             digit_idx_r;
   logic [NDIGITS-1:0]     blank_s;
   logic                   carry_s;
   logic [4:0]             dstep_s;
   bcd_digit_t             cur_digit_s;
   bcd_digit_t             rom_code_s;
   logic                   rom_rd_s;

   assign value_bcd = value_r;
   assign rom_rd_s  = (state_r == WRITE);

   // Ripple +1/-1 through the digits; carry/borrow out of the MSD is dropped, so the count wraps.
   always_comb begin
      carry_s      = 1'b1;
      dstep_s      = 5'd0;
      value_next_s = value_r;
      for (int i = 0; i < NDIGITS; i++) begin
         dstep_s = bcd_digit_step(value_r[4*i +: 4], inc_pulse, carry_s);
         value_next_s[4*i +: 4] = dstep_s[3:0];
         carry_s = dstep_s[4];
      end
   end

`ifdef LEADING_ZERO_BLANK_EN
   logic nz_seen_s;

   // Mark zero digits above the first nonzero one; digit0 is never blanked.
   always_comb begin
      nz_seen_s = 1'b0;
      blank_s   = '0;
      for (int d = NDIGITS-1; d >= 0; d--) begin
         if (value_r[4*d +: 4] != 4'd0) begin
            nz_seen_s = 1'b1;
         end else begin
            nz_seen_s = nz_seen_s;
         end
         blank_s[d] = (d != 0) && !nz_seen_s;
      end
   end
`else
   // Every digit is drawn, leading zeros included.
   always_comb begin
      blank_s = '0;
   end
`endif

   // ROM code for the current column: gap columns and blanked digits use a blank code.
   always_comb begin
      cur_digit_s = value_r[4*digit_idx_r +: 4];
      if ((int'(glyph_r) >= GLYPH_COLS) || blank_s[digit_idx_r]) begin
         rom_code_s = 4'hF;
      end else begin
         rom_code_s = cur_digit_s;
      end
   end

   digit_font_rom #(
      .ROWS  (ROWS),
      .COL_W (G_W)
   ) u_font_rom (
      .clk   (clk),
      .rst   (rst),
      .rd_en (rom_rd_s),
      .digit (rom_code_s),
      .col   (glyph_r),
      .data  (fb_wdata)
   );

   // Redraw sequencer: value update on accepted pulses, column walk, registered write strobes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= WRITE;
         value_r     <= '0;
         col_r       <= '0;
         glyph_r     <= '0;
         digit_idx_r <= 2'(NDIGITS-1);
         fb_we       <= 1'b0;
         fb_addr     <= '0;
         done        <= 1'b0;
         busy        <= 1'b1;
      end else begin
         case (state_r)
            IDLE: begin
               fb_we <= 1'b0;
               done  <= 1'b0;
               if (inc_pulse ^ dec_pulse) begin
                  value_r     <= value_next_s;
                  col_r       <= '0;
                  glyph_r     <= '0;
                  digit_idx_r <= 2'(NDIGITS-1);
                  busy        <= 1'b1;
                  state_r     <= WRITE;
               end else begin
                  busy    <= 1'b0;
                  state_r <= IDLE;
               end
            end
            WRITE: begin
               // The ROM read issued now lands next cycle, together with this address.
               fb_we   <= 1'b1;
               fb_addr <= FB_ADDR_W'(BASE_COL) + FB_ADDR_W'(col_r);
               busy    <= 1'b1;
               if (int'(col_r) == TOTAL-1) begin
                  done    <= 1'b1;
                  state_r <= FLUSH;
               end else begin
                  done    <= 1'b0;
                  state_r <= WRITE;
                  col_r   <= col_r + COL_W'(1);
                  if (int'(glyph_r) == COLS_PER-1) begin
                     glyph_r     <= '0;
                     digit_idx_r <= digit_idx_r - 2'd1;
                  end else begin
                     glyph_r <= glyph_r + G_W'(1);
                  end
               end
            end
            FLUSH: begin
               fb_we   <= 1'b0;
               done    <= 1'b0;
               busy    <= 1'b0;
               state_r <= IDLE;
            end
            default: begin
               fb_we   <= 1'b0;
               done    <= 1'b0;
               busy    <= 1'b0;
               state_r <= IDLE;
            end
         endcase
      end
   end

endmodule
